// File: rtl/timer_prescaler_bank.sv
// rtl/timer_prescaler_bank.sv - bank of independent prescaled period timers with overflow flags and IRQ
module timer_prescaler_bank #(
  parameter int CHANNELS = 4,
  parameter int PRESC_W  = 8,
  parameter int CNT_W    = 16
) (
  input  logic                        CLK,
  input  logic                        CPU_Reset_n,
  input  logic                        TIMER_EN,
  input  logic [CHANNELS-1:0]         TIMER_START,
  input  logic [CHANNELS-1:0]         TIMER_STOP,
  input  logic [CHANNELS-1:0]         TIMER_ONESHOT,
  input  logic [CHANNELS*PRESC_W-1:0] TIMER_CONFIG_PRESCALER,
  input  logic [CHANNELS*CNT_W-1:0]   TIMER_CONFIG_PERIOD,
  input  logic [CHANNELS-1:0]         TIMER_OV_CLR,
  input  logic [CHANNELS-1:0]         TIMER_IRQ_EN,
  output logic [CHANNELS*CNT_W-1:0]   TIMER_CNT,
  output logic [CHANNELS-1:0]         TIMER_BUSY,
  output logic [CHANNELS-1:0]         TIMER_OV_PULSE,
  output logic [CHANNELS-1:0]         TIMER_OV_FLAG,
  output logic                        TIMER_IRQ
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [PRESC_W-1:0] PRESC_ONE = PRESC_W'(1);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [PRESC_W-1:0] cfg_presc;
    logic [CNT_W-1:0]   cfg_period;
    state_e             state_q, state_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pulse_q, pulse_d;
    logic               flag_q, flag_d;
    logic               busy_q, busy_d;

    assign cfg_presc  = TIMER_CONFIG_PRESCALER[g*PRESC_W +: PRESC_W];
    assign cfg_period = TIMER_CONFIG_PERIOD[g*CNT_W +: CNT_W];

    // Next-state: STOP beats START; counting only in RUN on enabled edges; >= guards against
    // a terminal value reprogrammed below the live count.
    always_comb begin
      state_d = state_q;
      presc_d = presc_q;
      cnt_d   = cnt_q;
      pulse_d = 1'b0;
      flag_d  = flag_q;
      if (TIMER_STOP[g]) begin
        state_d = ST_IDLE;
      end else if (TIMER_START[g]) begin
        state_d = ST_RUN;
        presc_d = '0;
        cnt_d   = '0;
      end else if (state_q == ST_RUN && TIMER_EN) begin
        if (presc_q >= cfg_presc) begin
          presc_d = '0;
          if (cnt_q >= cfg_period) begin
            cnt_d   = '0;
            pulse_d = 1'b1;
            if (TIMER_ONESHOT[g]) begin
              state_d = ST_DONE;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          presc_d = presc_q + PRESC_ONE;
        end
      end
      if (TIMER_OV_CLR[g]) begin
        flag_d = 1'b0;
      end
      if (pulse_d) begin
        flag_d = 1'b1;
      end
      busy_d = (state_d == ST_RUN);
    end

    // Channel state and registered outputs; reset returns everything to zero immediately.
    always_ff @(posedge CLK or negedge CPU_Reset_n) begin
      if (!CPU_Reset_n) begin
        state_q <= ST_IDLE;
        presc_q <= '0;
        cnt_q   <= '0;
        pulse_q <= 1'b0;
        flag_q  <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        presc_q <= presc_d;
        cnt_q   <= cnt_d;
        pulse_q <= pulse_d;
        flag_q  <= flag_d;
        busy_q  <= busy_d;
      end
    end

    assign TIMER_CNT[g*CNT_W +: CNT_W] = cnt_q;
    assign TIMER_BUSY[g]               = busy_q;
    assign TIMER_OV_PULSE[g]           = pulse_q;
    assign TIMER_OV_FLAG[g]            = flag_q;
  end

  assign TIMER_IRQ = |(TIMER_OV_FLAG & TIMER_IRQ_EN);

endmodule

// File: tb/tb_timer_prescaler_bank.sv
// tb/tb_timer_prescaler_bank.sv - scoreboard bench for timer_prescaler_bank
module tb_timer_prescaler_bank;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [3:0]  start;
  logic [3:0]  stop;
  logic [3:0]  oneshot;
  logic [31:0] presc_bus;
  logic [63:0] per_bus;
  logic [3:0]  ov_clr;
  logic [3:0]  irq_en;
  logic [63:0] cnt_bus;
  logic [3:0]  busy;
  logic [3:0]  ov_pulse;
  logic [3:0]  ov_flag;
  logic        irq;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int exp_q [4][$];

  timer_prescaler_bank #(.CHANNELS(4), .PRESC_W(8), .CNT_W(16)) dut (
    .CLK                    (clk),
    .CPU_Reset_n            (rst_n),
    .TIMER_EN               (en),
    .TIMER_START            (start),
    .TIMER_STOP             (stop),
    .TIMER_ONESHOT          (oneshot),
    .TIMER_CONFIG_PRESCALER (presc_bus),
    .TIMER_CONFIG_PERIOD    (per_bus),
    .TIMER_OV_CLR           (ov_clr),
    .TIMER_IRQ_EN           (irq_en),
    .TIMER_CNT              (cnt_bus),
    .TIMER_BUSY             (busy),
    .TIMER_OV_PULSE         (ov_pulse),
    .TIMER_OV_FLAG          (ov_flag),
    .TIMER_IRQ              (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  function automatic logic [15:0] cnt_of(input int ch);
    return cnt_bus[ch*16 +: 16];
  endfunction

  // Monitor: every pulse presented (or expected) on a channel is matched against the scoreboard.
  always @(negedge clk) begin
    logic exp_b;
    for (int i = 0; i < 4; i++) begin
      exp_b = (exp_q[i].size() > 0) && (exp_q[i][0] == cyc);
      if (ov_pulse[i] || exp_b) begin
        chk($sformatf("ov_pulse_ch%0d", i), 64'(ov_pulse[i]), 64'(exp_b));
        if (exp_b) void'(exp_q[i].pop_front());
      end
    end
  end

  task automatic set_cfg(input int ch, input int p, input int t);
    presc_bus[ch*8 +: 8]  = 8'(p);
    per_bus[ch*16 +: 16]  = 16'(t);
  endtask

  task automatic start_ch(input int ch, output int s);
    s = cyc + 1;
    start[ch] = 1'b1;
    @(negedge clk);
    start[ch] = 1'b0;
  endtask

  task automatic stop_ch(input int ch);
    stop[ch] = 1'b1;
    @(negedge clk);
    stop[ch] = 1'b0;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, s2, s3;
    logic [15:0] seq [7];
    seq = '{16'd0, 16'd0, 16'd1, 16'd1, 16'd2, 16'd2, 16'd0};
    rst_n = 1'b0; en = 1'b1; start = '0; stop = '0; oneshot = '0;
    presc_bus = '0; per_bus = '0; ov_clr = '0; irq_en = '0;
    repeat (3) @(negedge clk);
    chk("reset_cnt",   cnt_bus, 64'd0);
    chk("reset_busy",  64'(busy), 64'd0);
    chk("reset_flag",  64'(ov_flag), 64'd0);
    chk("reset_irq",   64'(irq), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: ch0 auto-reload P=1 T=2
    set_cfg(0, 1, 2);
    start_ch(0, s);
    exp_q[0].push_back(s + 6);
    exp_q[0].push_back(s + 12);
    exp_q[0].push_back(s + 18);
    chk("t1_busy", 64'(busy[0]), 64'd1);
    chk("t1_cnt0", 64'(cnt_of(0)), 64'(seq[0]));
    for (int k = 1; k < 7; k++) begin
      @(negedge clk);
      chk($sformatf("t1_cnt%0d", k), 64'(cnt_of(0)), 64'(seq[k]));
    end
    wait_cyc(s + 18);
    stop_ch(0);
    chk("t1_stop_busy", 64'(busy[0]), 64'd0);

    // 2: ch1 one-shot P=0 T=3
    oneshot[1] = 1'b1;
    set_cfg(1, 0, 3);
    start_ch(1, s);
    exp_q[1].push_back(s + 4);
    chk("t2_busy_run", 64'(busy[1]), 64'd1);
    wait_cyc(s + 4);
    chk("t2_busy_done", 64'(busy[1]), 64'd0);
    chk("t2_cnt_done", 64'(cnt_of(1)), 64'd0);
    repeat (50) @(negedge clk);
    chk("t2_busy_late", 64'(busy[1]), 64'd0);
    chk("t2_cnt_late", 64'(cnt_of(1)), 64'd0);
    oneshot[1] = 1'b0;

    // 3: reprogram terminals below live values on ch2
    set_cfg(2, 0, 100);
    start_ch(2, s);
    wait_cyc(s + 10);
    chk("t3_cnt10", 64'(cnt_of(2)), 64'd10);
    set_cfg(2, 0, 5);
    exp_q[2].push_back(s + 11);
    @(negedge clk);
    chk("t3_cnt_wrap", 64'(cnt_of(2)), 64'd0);
    chk("t3_flag", 64'(ov_flag[2]), 64'd1);
    set_cfg(2, 20, 100);
    start_ch(2, s2);
    wait_cyc(s2 + 10);
    chk("t3_cnt_presc_hold", 64'(cnt_of(2)), 64'd0);
    set_cfg(2, 3, 100);
    @(negedge clk);
    chk("t3_cnt_tick", 64'(cnt_of(2)), 64'd1);
    stop_ch(2);

    // 4: global enable freeze on ch3, then STOP+START together
    set_cfg(3, 1, 4);
    start_ch(3, s);
    exp_q[3].push_back(s + 17);
    wait_cyc(s + 3);
    chk("t4_cnt_pre", 64'(cnt_of(3)), 64'd1);
    en = 1'b0;
    repeat (7) @(negedge clk);
    chk("t4_cnt_frozen", 64'(cnt_of(3)), 64'd1);
    en = 1'b1;
    wait_cyc(s + 17);
    start[3] = 1'b1; stop[3] = 1'b1;
    @(negedge clk);
    start[3] = 1'b0; stop[3] = 1'b0;
    chk("t4_stop_wins_busy", 64'(busy[3]), 64'd0);
    @(negedge clk);
    chk("t4_stop_wins_busy2", 64'(busy[3]), 64'd0);

    // 5: overflow flag vs clear, IRQ masking
    ov_clr = 4'hF;
    @(negedge clk);
    ov_clr = 4'h0;
    chk("t5_flags_clr", 64'(ov_flag), 64'd0);
    irq_en = 4'b1000;
    set_cfg(0, 0, 1);
    start_ch(0, s);
    exp_q[0].push_back(s + 2);
    exp_q[0].push_back(s + 4);
    wait_cyc(s + 3);
    ov_clr[0] = 1'b1;
    @(negedge clk);
    ov_clr[0] = 1'b0;
    chk("t5_flag_wrap_clr", 64'(ov_flag[0]), 64'd1);
    chk("t5_irq_masked", 64'(irq), 64'd0);
    stop_ch(0);
    set_cfg(3, 0, 0);
    start_ch(3, s3);
    exp_q[3].push_back(s3 + 1);
    exp_q[3].push_back(s3 + 2);
    exp_q[3].push_back(s3 + 3);
    @(negedge clk);
    chk("t5_irq_ch3", 64'(irq), 64'd1);
    wait_cyc(s3 + 3);
    stop_ch(3);
    ov_clr[3] = 1'b1;
    @(negedge clk);
    ov_clr[3] = 1'b0;
    chk("t5_irq_cleared", 64'(irq), 64'd0);
    chk("t5_flag0_kept", 64'(ov_flag[0]), 64'd1);

    // 6: asynchronous reset mid-period
    set_cfg(1, 0, 50);
    start_ch(1, s);
    repeat (5) @(negedge clk);
    chk("t6_cnt_pre", 64'(cnt_of(1)), 64'd5);
    #1 rst_n = 1'b0;
    #2;
    chk("t6_rst_cnt",   cnt_bus, 64'd0);
    chk("t6_rst_busy",  64'(busy), 64'd0);
    chk("t6_rst_pulse", 64'(ov_pulse), 64'd0);
    chk("t6_rst_flag",  64'(ov_flag), 64'd0);
    chk("t6_rst_irq",   64'(irq), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("t6_post_busy", 64'(busy), 64'd0);
    chk("t6_post_cnt",  cnt_bus, 64'd0);

    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("pending_pulses_ch%0d", i), 64'(exp_q[i].size()), 64'd0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
